// File: rtl/dmi_arbiter.sv
// Two-requester DMI arbiter: round-robin grant, one downstream transaction outstanding at a time.
// Define DMI_ARB_TIMEOUT_EN to add the response timeout (ERR/DRAIN states and wait counter).
module dmi_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [6:0]  req0_addr,
    input  logic [1:0]  req0_op,
    input  logic [31:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [6:0]  req1_addr,
    input  logic [1:0]  req1_op,
    input  logic [31:0] req1_data,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic [1:0]  resp0_resp,
    output logic [31:0] resp0_data,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [1:0]  resp1_resp,
    output logic [31:0] resp1_data,
    output logic        dmi_req_valid,
    input  logic        dmi_req_ready,
    output logic [6:0]  dmi_req_addr,
    output logic [1:0]  dmi_req_op,
    output logic [31:0] dmi_req_data,
    input  logic        dmi_resp_valid,
    output logic        dmi_resp_ready,
    input  logic [1:0]  dmi_resp_resp,
    input  logic [31:0] dmi_resp_data,
    output logic        busy,
    output logic        owner
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
        $error("dmi_arbiter: TIMEOUT_CYCLES out of range 2..65535");
    end

`ifdef DMI_ARB_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, REQ, RESP, ERR, DRAIN} state_t;
`else
    typedef enum logic [2:0] {IDLE, REQ, RESP} state_t;
`endif

    state_t      state, state_next;
    logic        last_grant;
    logic        grant;
    logic        accept;
    logic        owner_ready;
    logic [1:0]  resp_resp_mux;
    logic [31:0] resp_data_mux;
    logic [6:0]  req_addr_p0;
    logic [1:0]  req_op_p0;
    logic [31:0] req_data_p0;

`ifdef DMI_ARB_TIMEOUT_EN
    localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);
    logic [16:0] wait_cnt;
    logic [16:0] wait_cnt_inc;
    assign wait_cnt_inc = wait_cnt + 17'd1;
`endif

    // Tie goes to the requester that did not win last time.
    assign grant       = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign owner_ready = owner ? resp1_ready : resp0_ready;

    always_comb begin
        state_next     = state;
        accept         = 1'b0;
        req0_ready     = 1'b0;
        req1_ready     = 1'b0;
        dmi_req_valid  = 1'b0;
        dmi_resp_ready = 1'b0;
        resp0_valid    = 1'b0;
        resp1_valid    = 1'b0;
        resp_resp_mux  = dmi_resp_resp;
        resp_data_mux  = dmi_resp_data;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept     = 1'b1;
                    req0_ready = ~grant;
                    req1_ready = grant;
                    state_next = REQ;
                end
            end
            REQ: begin
                dmi_req_valid = 1'b1;
                if (dmi_req_ready) state_next = RESP;
            end
            RESP: begin
                dmi_resp_ready = owner_ready;
                resp0_valid    = dmi_resp_valid & ~owner;
                resp1_valid    = dmi_resp_valid & owner;
                if (dmi_resp_valid && owner_ready) state_next = IDLE;
`ifdef DMI_ARB_TIMEOUT_EN
                // A response arriving on the limit cycle takes priority over the timeout.
                else if (!dmi_resp_valid && wait_cnt_inc == TIMEOUT_LIMIT) state_next = ERR;
`endif
            end
`ifdef DMI_ARB_TIMEOUT_EN
            ERR: begin
                resp_resp_mux = 2'b10;
                resp_data_mux = '0;
                resp0_valid   = ~owner;
                resp1_valid   = owner;
                if (owner_ready) state_next = DRAIN;
            end
            DRAIN: begin
                dmi_resp_ready = 1'b1;
                if (dmi_resp_valid) state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                owner      <= grant;
                last_grant <= grant;
            end
        end
    end

    // Request capture stage: fields held stable until the downstream accepts.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_addr_p0 <= grant ? req1_addr : req0_addr;
            req_op_p0   <= grant ? req1_op   : req0_op;
            req_data_p0 <= grant ? req1_data : req0_data;
        end
    end

`ifdef DMI_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset || state != RESP) wait_cnt <= '0;
        else if (!dmi_resp_valid)   wait_cnt <= wait_cnt_inc;
    end
`endif

    assign dmi_req_addr = req_addr_p0;
    assign dmi_req_op   = req_op_p0;
    assign dmi_req_data = req_data_p0;
    assign resp0_resp   = resp_resp_mux;
    assign resp0_data   = resp_data_mux;
    assign resp1_resp   = resp_resp_mux;
    assign resp1_data   = resp_data_mux;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed self-checking bench for dmi_arbiter; timeout scenario runs when DMI_ARB_TIMEOUT_EN is defined.
module tb_dmi_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [6:0]  req0_addr, req1_addr;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_data, req1_data;
    logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [1:0]  resp0_resp, resp1_resp;
    logic [31:0] resp0_data, resp1_data;
    logic        dmi_req_valid, dmi_req_ready;
    logic [6:0]  dmi_req_addr;
    logic [1:0]  dmi_req_op;
    logic [31:0] dmi_req_data;
    logic        dmi_resp_valid, dmi_resp_ready;
    logic [1:0]  dmi_resp_resp;
    logic [31:0] dmi_resp_data;
    logic        busy, owner;

    int   total = 0;
    int   bad = 0;
    logic hs_clr = 1'b0;
    int   hs0_cnt = 0;
    logic resp1_seen = 1'b0;

    dmi_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_op(req0_op), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_op(req1_op), .req1_data(req1_data),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_resp(resp0_resp),
        .resp0_data(resp0_data),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_resp(resp1_resp),
        .resp1_data(resp1_data),
        .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
        .dmi_req_addr(dmi_req_addr), .dmi_req_op(dmi_req_op), .dmi_req_data(dmi_req_data),
        .dmi_resp_valid(dmi_resp_valid), .dmi_resp_ready(dmi_resp_ready),
        .dmi_resp_resp(dmi_resp_resp), .dmi_resp_data(dmi_resp_data),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (hs_clr) begin
            hs0_cnt    <= 0;
            resp1_seen <= 1'b0;
        end else begin
            if (resp0_valid && resp0_ready) hs0_cnt <= hs0_cnt + 1;
            if (resp1_valid) resp1_seen <= 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_addr = '0; req0_op = '0; req0_data = '0;
        req1_valid = 0; req1_addr = '0; req1_op = '0; req1_data = '0;
        resp0_ready = 0; resp1_ready = 0;
        dmi_req_ready = 0; dmi_resp_valid = 0; dmi_resp_resp = '0; dmi_resp_data = '0;
    endtask

    task automatic do_reset();
        reset = 1;
        idle_inputs();
        tick();
        tick();
        reset = 0;
        #1;
    endtask

    task automatic clear_monitors();
        hs_clr = 1;
        tick();
        hs_clr = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({req0_ready, req1_ready, dmi_req_valid, dmi_resp_ready, resp0_valid, resp1_valid, busy} !== 7'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=0", {req0_ready, req1_ready, dmi_req_valid, dmi_resp_ready, resp0_valid, resp1_valid, busy});
        end
        total++;
        if (owner !== 1'b0) begin bad++; $display("FAIL reset_owner got=%b exp=0", owner); end
        req0_valid = 1; req1_valid = 1;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL reset_first_tie got=%b exp=10", {req0_ready, req1_ready}); end
        idle_inputs();
        #1;
    endtask

    task automatic test_single();
        clear_monitors();
        req0_valid = 1; req0_addr = 7'h10; req0_op = 2'd2; req0_data = 32'hDEADBEEF;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL single_grant got=%b exp=10", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 0; req0_addr = '0; req0_data = '0;
        #1;
        total++;
        if ({dmi_req_valid, dmi_req_addr, dmi_req_op, dmi_req_data} !== {1'b1, 7'h10, 2'd2, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL single_req got=%h exp=%h", {dmi_req_valid, dmi_req_addr, dmi_req_op, dmi_req_data}, {1'b1, 7'h10, 2'd2, 32'hDEADBEEF});
        end
        total++;
        if ({busy, owner} !== 2'b10) begin bad++; $display("FAIL single_busy_owner got=%b exp=10", {busy, owner}); end
        dmi_req_ready = 1;
        tick();
        dmi_req_ready = 0; resp0_ready = 1;
        #1;
        total++;
        if ({dmi_req_valid, resp0_valid} !== 2'b00) begin bad++; $display("FAIL single_resp_wait got=%b exp=00", {dmi_req_valid, resp0_valid}); end
        tick();
        dmi_resp_valid = 1; dmi_resp_resp = 2'b00; dmi_resp_data = 32'h1234;
        #1;
        total++;
        if ({resp0_valid, resp0_resp, resp0_data, dmi_resp_ready} !== {1'b1, 2'b00, 32'h1234, 1'b1}) begin
            bad++;
            $display("FAIL single_resp got=%h exp=%h", {resp0_valid, resp0_resp, resp0_data, dmi_resp_ready}, {1'b1, 2'b00, 32'h1234, 1'b1});
        end
        tick();
        dmi_resp_valid = 0; resp0_ready = 0;
        #1;
        total++;
        if ({busy, resp1_seen} !== 2'b00) begin bad++; $display("FAIL single_end got=%b exp=00", {busy, resp1_seen}); end
        total++;
        if (hs0_cnt !== 1) begin bad++; $display("FAIL single_resp_count got=%0d exp=1", hs0_cnt); end
    endtask

    task automatic test_round_robin();
        logic g;
        do_reset();
        req0_valid = 1; req0_addr = 7'h20; req0_op = 2'd1; req0_data = 32'hA0;
        req1_valid = 1; req1_addr = 7'h31; req1_op = 2'd2; req1_data = 32'hB1;
        dmi_req_ready = 1; dmi_resp_valid = 1; dmi_resp_data = 32'h99;
        resp0_ready = 1; resp1_ready = 1;
        #1;
        for (int i = 0; i < 4; i++) begin
            g = i[0];
            total++;
            if ({req0_ready, req1_ready} !== (g ? 2'b01 : 2'b10)) begin
                bad++; $display("FAIL rr_grant txn=%0d got=%b exp_owner=%b", i, {req0_ready, req1_ready}, g);
            end
            tick();
            total++;
            if ({owner, dmi_req_valid, dmi_req_addr, req0_ready, req1_ready} !== {g, 1'b1, (g ? 7'h31 : 7'h20), 2'b00}) begin
                bad++; $display("FAIL rr_req txn=%0d got=%h exp=%h", i, {owner, dmi_req_valid, dmi_req_addr, req0_ready, req1_ready}, {g, 1'b1, (g ? 7'h31 : 7'h20), 2'b00});
            end
            tick();
            total++;
            if ({dmi_req_valid, resp0_valid, resp1_valid} !== {1'b0, ~g, g}) begin
                bad++; $display("FAIL rr_resp txn=%0d got=%b exp=%b", i, {dmi_req_valid, resp0_valid, resp1_valid}, {1'b0, ~g, g});
            end
            tick();
        end
        idle_inputs();
        #1;
    endtask

    task automatic test_backpressure();
        clear_monitors();
        req0_valid = 1; req0_addr = 7'h45; req0_op = 2'd1; req0_data = 32'hCAFEF00D;
        #1;
        tick();
        req0_valid = 0; req0_addr = '0; req0_op = '0; req0_data = '0;
        #1;
        for (int k = 0; k < 5; k++) begin
            total++;
            if ({dmi_req_valid, dmi_req_addr, dmi_req_op, dmi_req_data, busy} !== {1'b1, 7'h45, 2'd1, 32'hCAFEF00D, 1'b1}) begin
                bad++; $display("FAIL bp_req_hold cyc=%0d got=%h", k, {dmi_req_valid, dmi_req_addr, dmi_req_op, dmi_req_data, busy});
            end
            tick();
        end
        dmi_req_ready = 1;
        #1;
        tick();
        dmi_req_ready = 0; dmi_resp_valid = 1; dmi_resp_resp = 2'b01; dmi_resp_data = 32'h55;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({resp0_valid, resp0_resp, resp0_data, dmi_resp_ready, busy} !== {1'b1, 2'b01, 32'h55, 1'b0, 1'b1}) begin
                bad++; $display("FAIL bp_resp_hold cyc=%0d got=%h", k, {resp0_valid, resp0_resp, resp0_data, dmi_resp_ready, busy});
            end
            tick();
        end
        resp0_ready = 1;
        #1;
        total++;
        if (dmi_resp_ready !== 1'b1) begin bad++; $display("FAIL bp_resp_ready got=%b exp=1", dmi_resp_ready); end
        tick();
        dmi_resp_valid = 0; resp0_ready = 0;
        #1;
        total++;
        if ({busy, resp0_valid} !== 2'b00) begin bad++; $display("FAIL bp_end got=%b exp=00", {busy, resp0_valid}); end
        total++;
        if (hs0_cnt !== 1) begin bad++; $display("FAIL bp_resp_count got=%0d exp=1", hs0_cnt); end
    endtask

    task automatic test_reset_mid();
        req1_valid = 1; req1_addr = 7'h7F; req1_op = 2'd3; req1_data = 32'h11;
        #1;
        tick();
        req1_valid = 0; dmi_req_ready = 1;
        tick();
        dmi_req_ready = 0; dmi_resp_valid = 1; resp1_ready = 0;
        #1;
        total++;
        if ({resp1_valid, owner} !== 2'b11) begin bad++; $display("FAIL mid_pending got=%b exp=11", {resp1_valid, owner}); end
        reset = 1;
        tick();
        reset = 0;
        #1;
        total++;
        if ({req0_ready, req1_ready, dmi_req_valid, dmi_resp_ready, resp0_valid, resp1_valid, busy, owner} !== 8'b0) begin
            bad++;
            $display("FAIL mid_reset_outputs got=%b exp=0", {req0_ready, req1_ready, dmi_req_valid, dmi_resp_ready, resp0_valid, resp1_valid, busy, owner});
        end
        idle_inputs();
        req0_valid = 1; req1_valid = 1;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL mid_tie got=%b exp=10", {req0_ready, req1_ready}); end
        tick();
        total++;
        if ({owner, busy} !== 2'b01) begin bad++; $display("FAIL mid_owner got=%b exp=01", {owner, busy}); end
        do_reset();
    endtask

`ifdef DMI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        req0_valid = 1; req0_addr = 7'h01;
        #1;
        tick();
        req0_valid = 0; dmi_req_ready = 1;
        tick();
        dmi_req_ready = 0; dmi_resp_resp = 2'b11; dmi_resp_data = 32'hFFFFFFFF;
        #1;
        for (int k = 0; k < 8; k++) begin
            total++;
            if ({resp0_valid, busy} !== 2'b01) begin bad++; $display("FAIL to_wait cyc=%0d got=%b exp=01", k, {resp0_valid, busy}); end
            tick();
        end
        total++;
        if ({resp0_valid, resp0_resp, resp0_data, dmi_resp_ready, resp1_valid} !== {1'b1, 2'b10, 32'h0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL to_err got=%h exp=%h", {resp0_valid, resp0_resp, resp0_data, dmi_resp_ready, resp1_valid}, {1'b1, 2'b10, 32'h0, 1'b0, 1'b0});
        end
        resp0_ready = 1;
        tick();
        resp0_ready = 0;
        #1;
        total++;
        if ({resp0_valid, dmi_resp_ready, busy} !== 3'b011) begin bad++; $display("FAIL to_drain got=%b exp=011", {resp0_valid, dmi_resp_ready, busy}); end
        dmi_resp_valid = 1;
        #1;
        total++;
        if (resp0_valid !== 1'b0) begin bad++; $display("FAIL to_discard got=%b exp=0", resp0_valid); end
        tick();
        dmi_resp_valid = 0;
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL to_idle got=%b exp=0", busy); end
        req0_valid = 1;
        #1;
        tick();
        req0_valid = 0; dmi_req_ready = 1;
        tick();
        dmi_req_ready = 0;
        #1;
        for (int k = 0; k < 7; k++) tick();
        dmi_resp_valid = 1; resp0_ready = 1; dmi_resp_resp = 2'b00; dmi_resp_data = 32'h77;
        #1;
        total++;
        if ({resp0_valid, resp0_resp, resp0_data} !== {1'b1, 2'b00, 32'h77}) begin
            bad++; $display("FAIL to_last_cycle got=%h exp=%h", {resp0_valid, resp0_resp, resp0_data}, {1'b1, 2'b00, 32'h77});
        end
        tick();
        dmi_resp_valid = 0; resp0_ready = 0;
        #1;
        total++;
        if ({busy, resp0_valid} !== 2'b00) begin bad++; $display("FAIL to_last_end got=%b exp=00", {busy, resp0_valid}); end
    endtask
`endif

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
`ifdef DMI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
